// File: rtl/kyber_pkg.sv
// Shared Kyber constants and types for the CBD sampler back end.
package kyber_pkg;

    localparam int KYBER_N       = 256;
    localparam int KYBER_Q       = 3329;
    localparam int KYBER_COEFF_W = 12;

    typedef logic signed [1:0]              cbd2_t;
    typedef logic [KYBER_COEFF_W-1:0]       coeff_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } strm_state_e;

    function automatic int beat_idx_w(input int lanes);
        int beats;
        beats = KYBER_N / lanes;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Signed sum of a whole CBD polynomial; 11 bits covers -512..+256.
    function automatic logic signed [10:0] cbd_sum(input cbd2_t [KYBER_N-1:0] f);
        logic signed [10:0] acc;
        acc = 11'sd0;
        for (int i = 0; i < KYBER_N; i++) begin
            acc = acc + {{9{f[i][1]}}, f[i]};
        end
        return acc;
    endfunction

endpackage

// File: rtl/cbd_coeff_streamer_if.sv
// Load and coefficient-stream handshake bundle of cbd_coeff_streamer.
interface cbd_coeff_streamer_if
    import kyber_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int COEFF_W = KYBER_COEFF_W,
    parameter int IDX_W   = beat_idx_w(LANES)
);

    logic                             load_valid;
    logic                             load_ready;
    cbd2_t [KYBER_N-1:0]              f_in;
    logic                             coeff_valid;
    logic                             coeff_ready;
    logic [LANES-1:0][COEFF_W-1:0]    coeff_out;
    logic [IDX_W-1:0]                 coeff_idx;
    logic                             coeff_last;

    modport slave (
        input  load_valid, f_in, coeff_ready,
        output load_ready, coeff_valid, coeff_out, coeff_idx, coeff_last
    );

    modport master (
        output load_valid, f_in, coeff_ready,
        input  load_ready, coeff_valid, coeff_out, coeff_idx, coeff_last
    );

endinterface

// File: rtl/cbd_coeff_streamer_modq_map.sv
// cbd_modq_map: maps one signed 2-bit CBD coefficient to its residue in [0, Q-1].
module cbd_modq_map
    import kyber_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  cbd2_t  c_in,
    output coeff_t r_out
);

    // Negative codes wrap to Q+c, non-negative codes pass through.
    always_comb begin
        r_out = 12'd0;
        case (c_in)
            2'b00:   r_out = 12'd0;
            2'b01:   r_out = 12'd1;
            2'b10:   r_out = coeff_t'(Q - 2);
            2'b11:   r_out = coeff_t'(Q - 1);
            default: r_out = 12'd0;
        endcase
    end

endmodule

// File: rtl/cbd_coeff_streamer.sv
// Captures a 256-coefficient CBD polynomial and streams its mod-Q residues LANES per beat.
// Optional build macro CBD_STREAM_SUM_EN adds sum_out/sum_valid (raw coefficient sum).
module cbd_coeff_streamer
    import kyber_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int Q       = KYBER_Q,
    parameter int COEFF_W = KYBER_COEFF_W
) (
    input  logic                clk,
    input  logic                reset,
    cbd_coeff_streamer_if.slave bus,
    output logic                busy
`ifdef CBD_STREAM_SUM_EN
    ,
    output logic signed [10:0]  sum_out,
    output logic                sum_valid
`endif
);

    localparam int               BEATS    = KYBER_N / LANES;
    localparam int               IDX_W    = beat_idx_w(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    strm_state_e                   state_r;
    strm_state_e                   state_s;
    logic [IDX_W-1:0]              cnt_r;
    cbd2_t [KYBER_N-1:0]           buf_r;
    cbd2_t [LANES-1:0]             slice_s;
    coeff_t [LANES-1:0]            mapped_s;
    logic [LANES-1:0][COEFF_W-1:0] coeff_out_s;
    logic                          load_ready_s;
    logic                          coeff_valid_s;
    logic                          last_s;
    logic                          load_fire_s;
    logic                          beat_fire_s;
    int                            base_s;

    assign last_s      = (cnt_r == LAST_IDX);
    assign load_fire_s = load_ready_s && bus.load_valid;
    assign beat_fire_s = coeff_valid_s && bus.coeff_ready;

    // Next-state and handshake outputs of the IDLE/STREAM controller.
    always_comb begin
        state_s       = state_r;
        load_ready_s  = 1'b0;
        coeff_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_ready_s = 1'b1;
                if (bus.load_valid) begin
                    state_s = ST_STREAM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                coeff_valid_s = 1'b1;
                if (bus.coeff_ready && last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Beat counter; wraps back to zero after the last beat since BEATS is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {IDX_W{1'b0}};
        end else if (load_fire_s) begin
            cnt_r <= {IDX_W{1'b0}};
        end else if (beat_fire_s) begin
            cnt_r <= cnt_r + IDX_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Capture buffer, written only on the load handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_r <= {(2*KYBER_N){1'b0}};
        end else if (load_fire_s) begin
            buf_r <= bus.f_in;
        end else begin
            buf_r <= buf_r;
        end
    end

    // Select the coefficients belonging to the current beat.
    always_comb begin
        base_s  = int'(cnt_r) * LANES;
        slice_s = buf_r[base_s +: LANES];
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        cbd_modq_map #(.Q(Q)) u_map (
            .c_in  (slice_s[k]),
            .r_out (mapped_s[k])
        );
    end

    // Residues are forced to zero whenever no beat is being offered.
    always_comb begin
        coeff_out_s = {(LANES*COEFF_W){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            if (coeff_valid_s) begin
                coeff_out_s[k] = COEFF_W'(mapped_s[k]);
            end else begin
                coeff_out_s[k] = {COEFF_W{1'b0}};
            end
        end
    end

    assign bus.load_ready  = load_ready_s;
    assign bus.coeff_valid = coeff_valid_s;
    assign bus.coeff_out   = coeff_out_s;
    assign bus.coeff_idx   = cnt_r;
    assign bus.coeff_last  = coeff_valid_s && last_s;
    assign busy            = (state_r == ST_STREAM);

`ifdef CBD_STREAM_SUM_EN
    // Sum of the raw polynomial, registered with the load so it lines up with beat 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_out   <= 11'sd0;
            sum_valid <= 1'b0;
        end else if (load_fire_s) begin
            sum_out   <= cbd_sum(bus.f_in);
            sum_valid <= 1'b1;
        end else begin
            sum_out   <= sum_out;
            sum_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cbd_coeff_streamer.sv
// Directed self-checking bench for cbd_coeff_streamer (LANES=4, 64 beats per polynomial).
module tb_cbd_coeff_streamer;
    import kyber_pkg::*;

    localparam int LANES   = 4;
    localparam int COEFF_W = 12;
    localparam int BEATS   = 64;
    localparam int BW      = LANES * COEFF_W;

    logic clk = 1'b0;
    logic reset;
    logic busy;
`ifdef CBD_STREAM_SUM_EN
    logic signed [10:0] sum_out;
    logic               sum_valid;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    cbd2_t [255:0] pat_a;
    cbd2_t [255:0] pat_b;
    cbd2_t [255:0] pat_r;

    cbd_coeff_streamer_if #(.LANES(LANES), .COEFF_W(COEFF_W)) bus ();

    cbd_coeff_streamer #(.LANES(LANES), .Q(3329), .COEFF_W(COEFF_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
`ifdef CBD_STREAM_SUM_EN
        ,
        .sum_out   (sum_out),
        .sum_valid (sum_valid)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference residue: decode the two's-complement code, add Q if negative.
    function automatic logic [11:0] ref_res(input logic [1:0] code);
        int v;
        v = code[1] ? int'(code) - 4 : int'(code);
        return (v < 0) ? 12'(3329 + v) : 12'(v);
    endfunction

    function automatic logic [BW-1:0] exp_beat(input cbd2_t [255:0] p, input int b);
        logic [BW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*COEFF_W +: COEFF_W] = ref_res(p[b*LANES + k]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.load_valid  = 1'b0;
        bus.coeff_ready = 1'b0;
        bus.f_in        = {256{2'b00}};
        repeat (3) tick();
        tests_run++;
        if (bus.load_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_load_ready: got %b want 1", bus.load_ready); end
        tests_run++;
        if (bus.coeff_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_coeff_valid: got %b want 0", bus.coeff_valid); end
        tests_run++;
        if (bus.coeff_out !== {BW{1'b0}}) begin tests_failed++; $display("FAIL reset_coeff_out: got %h want 0", bus.coeff_out); end
        tests_run++;
        if (bus.coeff_idx !== 6'd0 || bus.coeff_last !== 1'b0) begin
            tests_failed++; $display("FAIL reset_idx_last: got idx %0d last %b want 0 0", bus.coeff_idx, bus.coeff_last);
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        tick();
        tests_run++;
        if (bus.load_ready !== 1'b1 || bus.coeff_valid !== 1'b0) begin
            tests_failed++; $display("FAIL post_reset_idle: got ready %b valid %b want 1 0", bus.load_ready, bus.coeff_valid);
        end
    endtask

    task automatic test_zero_stream();
        bus.f_in        = {256{2'b00}};
        bus.coeff_ready = 1'b1;
        bus.load_valid  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            tests_run++;
            if ({bus.coeff_valid, bus.coeff_idx, bus.coeff_last, busy} !== {1'b1, 6'(b), (b == BEATS - 1), 1'b1}
                || bus.coeff_out !== {BW{1'b0}}) begin
                tests_failed++;
                $display("FAIL zero_beat_%0d: got valid %b idx %0d last %b busy %b out %h want 1 %0d %b 1 0",
                         b, bus.coeff_valid, bus.coeff_idx, bus.coeff_last, busy, bus.coeff_out, b, (b == BEATS - 1));
            end
            tick();
        end
        tests_run++;
        if (bus.load_ready !== 1'b1 || bus.coeff_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_after_last: got ready %b valid %b busy %b want 1 0 0", bus.load_ready, bus.coeff_valid, busy);
        end
    endtask

    task automatic test_pattern();
        logic [1:0] codes [5];
        // The +2 entry has no 2-bit encoding of its own; it truncates to 2'b10 and decodes as -2.
        codes = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 256; i++) pat_a[i] = codes[i % 5];
        bus.f_in        = pat_a;
        bus.coeff_ready = 1'b1;
        bus.load_valid  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            if (b == 0) begin
                tests_run++;
                if (bus.coeff_out !== {12'd1, 12'd0, 12'd3328, 12'd3327}) begin
                    tests_failed++; $display("FAIL pattern_beat0: got %h want 001_000_d00_cff", bus.coeff_out);
                end
            end
            if (b == 1) begin
                tests_run++;
                if (bus.coeff_out !== {12'd0, 12'd3328, 12'd3327, 12'd3327}) begin
                    tests_failed++; $display("FAIL pattern_beat1: got %h want 000_d00_cff_cff", bus.coeff_out);
                end
            end
            tests_run++;
            if (bus.coeff_out !== exp_beat(pat_a, b) || bus.coeff_idx !== 6'(b)) begin
                tests_failed++;
                $display("FAIL pattern_beat_%0d: got idx %0d out %h want idx %0d out %h", b, bus.coeff_idx, bus.coeff_out, b, exp_beat(pat_a, b));
            end
            for (int k = 0; k < LANES; k++) begin
                tests_run++;
                if (bus.coeff_out[k] >= 12'd3329) begin
                    tests_failed++; $display("FAIL pattern_range_%0d_%0d: got %0d want < 3329", b, k, bus.coeff_out[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int            exp_b;
        logic          stalled;
        logic          rdy;
        logic [BW-1:0] prev_out;
        logic [5:0]    prev_idx;
        for (int i = 0; i < 256; i++) pat_r[i] = 2'($urandom_range(0, 3));
        bus.f_in        = pat_r;
        bus.coeff_ready = 1'b0;
        bus.load_valid  = 1'b1;
        tick();
        bus.f_in = ~pat_r;
        exp_b    = 0;
        stalled  = 1'b0;
        prev_out = {BW{1'b0}};
        prev_idx = 6'd0;
        for (int cyc = 0; cyc < 1000 && exp_b < BEATS; cyc++) begin
            if (exp_b >= 60) bus.load_valid = 1'b0;
            tests_run++;
            if (bus.load_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_load_ignored: got ready %b want 0", bus.load_ready); end
            tests_run++;
            if (bus.coeff_valid !== 1'b1 || bus.coeff_idx !== 6'(exp_b) || bus.coeff_last !== (exp_b == BEATS - 1)
                || bus.coeff_out !== exp_beat(pat_r, exp_b)) begin
                tests_failed++;
                $display("FAIL bp_beat_%0d: got valid %b idx %0d last %b out %h want 1 %0d %b %h",
                         exp_b, bus.coeff_valid, bus.coeff_idx, bus.coeff_last, bus.coeff_out, exp_b, (exp_b == BEATS - 1), exp_beat(pat_r, exp_b));
            end
            if (stalled) begin
                tests_run++;
                if (bus.coeff_out !== prev_out || bus.coeff_idx !== prev_idx) begin
                    tests_failed++;
                    $display("FAIL bp_stall_stable: got idx %0d out %h want idx %0d out %h", bus.coeff_idx, bus.coeff_out, prev_idx, prev_out);
                end
            end
            rdy             = 1'($urandom_range(0, 1));
            bus.coeff_ready = rdy;
            prev_out        = bus.coeff_out;
            prev_idx        = bus.coeff_idx;
            stalled         = !rdy;
            if (rdy) exp_b++;
            tick();
        end
        bus.load_valid = 1'b0;
        tests_run++;
        if (exp_b != BEATS) begin tests_failed++; $display("FAIL bp_timeout: got %0d beats want %0d", exp_b, BEATS); end
        tests_run++;
        if (bus.load_ready !== 1'b1 || bus.coeff_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_end_idle: got ready %b valid %b want 1 0", bus.load_ready, bus.coeff_valid);
        end
    endtask

    task automatic test_reset_mid();
        pat_a           = {256{2'b01}};
        pat_b           = {256{2'b11}};
        bus.f_in        = pat_a;
        bus.coeff_ready = 1'b1;
        bus.load_valid  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        repeat (20) tick();
        tests_run++;
        if (bus.coeff_valid !== 1'b1 || bus.coeff_idx !== 6'd20) begin
            tests_failed++; $display("FAIL mid_pre_reset: got valid %b idx %0d want 1 20", bus.coeff_valid, bus.coeff_idx);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.coeff_valid !== 1'b0 || busy !== 1'b0 || bus.load_ready !== 1'b1 || bus.coeff_idx !== 6'd0 || bus.coeff_out !== {BW{1'b0}}) begin
            tests_failed++;
            $display("FAIL mid_async_reset: got valid %b busy %b ready %b idx %0d out %h want 0 0 1 0 0",
                     bus.coeff_valid, busy, bus.load_ready, bus.coeff_idx, bus.coeff_out);
        end
        tick();
        reset = 1'b0;
        tests_run++;
        if (bus.coeff_valid !== 1'b0 || busy !== 1'b0 || bus.load_ready !== 1'b1) begin
            tests_failed++; $display("FAIL mid_next_cycle: got valid %b busy %b ready %b want 0 0 1", bus.coeff_valid, busy, bus.load_ready);
        end
        tick();
        bus.f_in       = pat_b;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        tests_run++;
        if (bus.coeff_valid !== 1'b1 || bus.coeff_idx !== 6'd0 || bus.coeff_out !== {4{12'd3328}}) begin
            tests_failed++; $display("FAIL mid_reload: got valid %b idx %0d out %h want 1 0 d00x4", bus.coeff_valid, bus.coeff_idx, bus.coeff_out);
        end
        repeat (BEATS) tick();
        tests_run++;
        if (bus.load_ready !== 1'b1 || bus.coeff_valid !== 1'b0) begin
            tests_failed++; $display("FAIL mid_drain: got ready %b valid %b want 1 0", bus.load_ready, bus.coeff_valid);
        end
    endtask

    task automatic test_back_to_back();
        pat_a           = {256{2'b01}};
        pat_b           = {256{2'b11}};
        bus.f_in        = pat_a;
        bus.coeff_ready = 1'b1;
        bus.load_valid  = 1'b1;
        tick();
        bus.f_in = pat_b;
        for (int b = 0; b < BEATS; b++) begin
            tests_run++;
            if (bus.coeff_valid !== 1'b1 || bus.coeff_idx !== 6'(b) || bus.coeff_out !== {4{12'd1}}) begin
                tests_failed++;
                $display("FAIL b2b_first_%0d: got valid %b idx %0d out %h want 1 %0d 001x4", b, bus.coeff_valid, bus.coeff_idx, bus.coeff_out, b);
            end
            tick();
        end
        tests_run++;
        if (bus.load_ready !== 1'b1 || bus.coeff_valid !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_gap: got ready %b valid %b want 1 0", bus.load_ready, bus.coeff_valid);
        end
        tick();
        bus.load_valid = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            tests_run++;
            if (bus.coeff_valid !== 1'b1 || bus.coeff_idx !== 6'(b) || bus.coeff_out !== {4{12'd3328}}) begin
                tests_failed++;
                $display("FAIL b2b_second_%0d: got valid %b idx %0d out %h want 1 %0d d00x4", b, bus.coeff_valid, bus.coeff_idx, bus.coeff_out, b);
            end
            tick();
        end
        tests_run++;
        if (bus.load_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_end: got ready %b busy %b want 1 0", bus.load_ready, busy);
        end
    endtask

`ifdef CBD_STREAM_SUM_EN
    task automatic test_sum();
        logic [1:0]         codes [2];
        logic signed [10:0] sums  [2];
        codes = '{2'b10, 2'b01};
        sums  = '{-11'sd512, 11'sd256};
        bus.coeff_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            bus.f_in       = {256{codes[t]}};
            bus.load_valid = 1'b1;
            tick();
            bus.load_valid = 1'b0;
            tests_run++;
            if (sum_valid !== 1'b1 || sum_out !== sums[t]) begin
                tests_failed++; $display("FAIL sum_%0d: got valid %b sum %0d want 1 %0d", t, sum_valid, sum_out, sums[t]);
            end
            tick();
            tests_run++;
            if (sum_valid !== 1'b0) begin tests_failed++; $display("FAIL sum_pulse_%0d: got valid %b want 0", t, sum_valid); end
            repeat (BEATS - 1) tick();
            tests_run++;
            if (bus.load_ready !== 1'b1) begin tests_failed++; $display("FAIL sum_drain_%0d: got ready %b want 1", t, bus.load_ready); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_stream();
        test_pattern();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef CBD_STREAM_SUM_EN
        test_sum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
